// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdop_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } mdstate_t;

  function automatic logic MD_IS_MULDIV(mdop_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(mdop_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath for the sequencer: acc/q register pair with radix-2 shift-add and restoring-divide steps.
// Optional MULDIV_EARLY_OUT_EN adds the multiply early-out shift.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic                       is_div_i,
  input  logic                       signed_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic                       step_mul_i,
  input  logic                       step_div_i,
`ifdef MULDIV_EARLY_OUT_EN
  input  logic [$clog2(WIDTH)-1:0]   cnt_i,
`endif
  output logic [WIDTH-1:0]           hi_o,
  output logic [WIDTH-1:0]           lo_o,
  output logic                       eo_o
);

  logic [WIDTH-1:0]   acc_q, q_q, m_q;
  logic               is_div_q, neg_lo_q, neg_hi_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_q;
  logic [2*WIDTH-1:0] mul_nxt;

  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ok;

  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_q   = {mul_sum[0], q_q[WIDTH-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
  // After this step, cnt_i unprocessed multiplier bits sit at the bottom of q;
  // if they are all zero the remaining steps would only shift.
  logic rest_nz;
  always_comb begin
    rest_nz = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(cnt_i)) rest_nz = rest_nz | mul_q[i];
    end
  end
  assign eo_o    = step_mul_i && (cnt_i != '0) && !rest_nz;
  assign mul_nxt = eo_o ? ({mul_acc, mul_q} >> cnt_i) : {mul_acc, mul_q};
`else
  assign eo_o    = 1'b0;
  assign mul_nxt = {mul_acc, mul_q};
`endif

  assign div_sh   = {acc_q, q_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_ok   = ~div_diff[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      is_div_q <= is_div_i;
      if (is_div_i) begin
        q_q      <= a_mag;
        m_q      <= b_mag;
        // a zero divisor must leave the all-ones quotient un-negated
        neg_lo_q <= (a_neg ^ b_neg) & (b_i != '0);
        neg_hi_q <= a_neg;
      end else begin
        q_q      <= b_mag;
        m_q      <= a_mag;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= 1'b0;
      end
    end else if (step_mul_i) begin
      {acc_q, q_q} <= mul_nxt;
    end else if (step_div_i) begin
      acc_q <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      q_q   <= {q_q[WIDTH-2:0], div_ok};
    end
  end

  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  assign hi_o = is_div_q ? (neg_hi_q ? -acc_q : acc_q) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_o = is_div_q ? (neg_lo_q ? -q_q   : q_q)   : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: iteration FSM, counter and D-stage stall.
// Build option MULDIV_EARLY_OUT_EN lets multiplies finish early once the multiplier is exhausted.
//
// state    | meaning
// ST_IDLE  | waiting; MTHI/MTLO write directly
// ST_MUL   | one multiplier bit per cycle
// ST_DIV   | one quotient bit per cycle
// ST_FIXUP | sign correction, HI/LO write, done pulse
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  mdop_t            opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hilordD,
  input  logic             mdopD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stallmdD
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdstate_t          state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q;

  logic              load, eo;
  logic [WIDTH-1:0]  res_hi, res_lo;

  assign load = (state_q == ST_IDLE) && startE && MD_IS_MULDIV(opE);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .is_div_i   (md_is_div(opE)),
    .signed_i   (md_is_signed(opE)),
    .a_i        (srcaE),
    .b_i        (srcbE),
    .step_mul_i (state_q == ST_MUL),
    .step_div_i (state_q == ST_DIV),
`ifdef MULDIV_EARLY_OUT_EN
    .cnt_i      (cnt_q),
`endif
    .hi_o       (res_hi),
    .lo_o       (res_lo),
    .eo_o       (eo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (startE) begin
            case (opE)
              MD_MTHI: hi_q <= srcaE;
              MD_MTLO: lo_q <= srcaE;
              MD_MULT, MD_MULTU: begin
                state_q <= ST_MUL;
                cnt_q   <= CNT_LAST;
              end
              MD_DIV, MD_DIVU: begin
                state_q <= ST_DIV;
                cnt_q   <= CNT_LAST;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (eo || (cnt_q == '0)) state_q <= ST_FIXUP;
          else                     cnt_q   <= cnt_q - 1'b1;
        end
        ST_DIV: begin
          if (cnt_q == '0) state_q <= ST_FIXUP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_FIXUP: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

  // drops in the done cycle so an MFHI/MFLO behind the op reads the fresh value
  assign stallmdD = (busy | (startE & MD_IS_MULDIV(opE))) & (hilordD | mdopD);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed mult/div vectors, MT writes, stall window, mid-op reset.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0;
  mdop_t       opE = MD_MULTU;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic        hilordD = 1'b0, mdopD = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stallmdD;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .hilordD(hilordD), .mdopD(mdopD), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stallmdD(stallmdD)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          c0;
    int          lat;
  } exp_t;

  typedef struct {
    mdop_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, n_done = 0, cyc = 0, busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // cycle (relative to the start cycle) in which done is expected
  function automatic int exp_lat(input mdop_t op, input logic [31:0] b);
    logic [31:0] m;
    int          msb;
    m   = (op == MD_MULT && b[31]) ? -b : b;
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
`ifdef MULDIV_EARLY_OUT_EN
    if (!md_is_div(op)) return msb + 3;
`endif
    return 34 + 0 * msb;
  endfunction

  // monitor: pops the scoreboard whenever the DUT pulses done
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy) busy_run = busy_run + 1;
      if (done) begin
        n_done = n_done + 1;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: actual=done required=no_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_hi"}, hi, e.hi);
          chk({e.tag, "_lo"}, lo, e.lo);
          chk({e.tag, "_lat"}, 32'(cyc - e.c0), 32'(e.lat));
          chk({e.tag, "_busy"}, 32'(busy_run), 32'(e.lat - 1));
        end
      end
      if (!busy && !done) busy_run = 0;
    end
  end

  task automatic issue(input string tag, input mdop_t op, input logic [31:0] a, b,
                       input logic [31:0] ehi, elo);
    exp_t e;
    @(posedge clk); #1;
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.c0 = cyc; e.lat = exp_lat(op, b);
    sb.push_back(e);
    @(posedge clk); #1;
    startE = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual=no_done required=done within 200 cycles", tag);
      sb.delete();
    end
  endtask

  vec_t vecs[10] = '{
    '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{MD_MULTU, 32'h00000005, 32'h00000001, 32'h00000000, 32'h00000005},
    '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14},
    '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF},
    '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF}
  };

  initial begin
    int c0, lat, bad_stall, done_before;

    hilordD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_stall", 32'(stallmdD), 32'h0);
    reset   = 1'b0;
    hilordD = 1'b0;

    for (int v = 0; v < 10; v++) begin
      issue($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].hi, vecs[v].lo);
      wait_drain($sformatf("vec%0d", v));
    end

    @(posedge clk); #1;
    startE = 1'b1; opE = MD_MTHI; srcaE = 32'h000000AA;
    @(posedge clk); #1;
    startE = 1'b0;
    chk("mthi_hi", hi, 32'h000000AA);
    chk("mthi_busy", 32'(busy), 32'h0);
    startE = 1'b1; opE = MD_MTLO; srcaE = 32'h00000055;
    @(posedge clk); #1;
    startE = 1'b0;
    chk("mtlo_lo", lo, 32'h00000055);
    chk("mtlo_hi_kept", hi, 32'h000000AA);

    // MULT with an MFLO waiting in D: stall through busy, released in done cycle
    begin
      exp_t e;
      @(posedge clk); #1;
      startE = 1'b1; opE = MD_MULT; srcaE = 32'd6; srcbE = 32'd7; hilordD = 1'b1;
      c0  = cyc;
      lat = exp_lat(MD_MULT, 32'd7);
      e.tag = "stall_mult"; e.hi = 32'h0; e.lo = 32'd42; e.c0 = c0; e.lat = lat;
      sb.push_back(e);
      bad_stall = 0;
      @(negedge clk);
      if (stallmdD !== 1'b1) bad_stall++;
      @(posedge clk); #1;
      startE = 1'b0;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (k < lat && stallmdD !== 1'b1) bad_stall++;
        if (k == lat) chk("stall_done_cycle", 32'(stallmdD), 32'h0);
      end
      chk("stall_window_errs", 32'(bad_stall), 32'h0);
      hilordD = 1'b0;
      wait_drain("stall_mult");
    end

    // reset ten cycles into a DIV: no HI/LO write, no done
    @(posedge clk); #1;
    startE = 1'b1; opE = MD_DIV; srcaE = 32'hFFFFFFF9; srcbE = 32'd2;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    done_before = n_done;
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #2;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(n_done - done_before), 32'h0);
    chk("midrst_idle_busy", 32'(busy), 32'h0);
    chk("midrst_hi_after", hi, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
